// File: rtl/input_debouncer_if.sv
// Pin-side bundle for the debouncer: raw pins in, clean level and edge strobes out.
// The debouncer takes the slave view; whatever drives the pins and consumes O takes master.
interface input_debouncer_if #(
    parameter int unsigned WIDTH = 2
);
    logic [WIDTH-1:0] I;
    logic [WIDTH-1:0] O;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (
        output I,
        input  O,
        input  RISE,
        input  FALL
    );

    modport slave (
        input  I,
        output O,
        output RISE,
        output FALL
    );
endinterface

// File: rtl/input_debouncer.sv
// Per-bit two-flop synchroniser followed by a stability counter.
// O only changes after DEBOUNCE_CYCLES consecutive synchronised mismatches.
module input_debouncer #(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 60000,
    parameter int unsigned CNT_W           = 16
) (
    input logic              CLK,
    input logic              RESETN,
    input_debouncer_if.slave bus
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
        $error("input_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Any cycle where the synchronised pin agrees with O restarts qualification.
    always_comb begin
        o_d    = o_q;
        rise_d = '0;
        fall_d = '0;
        for (int b = 0; b < WIDTH; b++) begin
            cnt_d[b] = '0;
            if (s_q[b] != o_q[b]) begin
                if (cnt_q[b] == CntLast) begin
                    o_d[b]    = s_q[b];
                    rise_d[b] = s_q[b];
                    fall_d[b] = ~s_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1_q   <= '0;
            s_q    <= '0;
            o_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            s1_q   <= bus.I;
            s_q    <= s1_q;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int b = 0; b < WIDTH; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    assign bus.O    = o_q;
    assign bus.RISE = rise_q;
    assign bus.FALL = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: directed tables, corner sequences, and a random run
// against a sliding-window reference (O flips when the last D synced samples all disagree).
module tb_input_debouncer;

    localparam int D = 4;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    input_debouncer_if #(.WIDTH(2)) bus ();
    input_debouncer_if #(.WIDTH(2)) bus1 ();

    input_debouncer #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .CLK   (clk),
        .RESETN(rstn),
        .bus   (bus.slave)
    );

    input_debouncer #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (16)
    ) dut1 (
        .CLK   (clk),
        .RESETN(rstn),
        .bus   (bus1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: two-stage delay, then a window of the last D synced samples.
    logic [1:0]     m_s1, m_s, m_o, m_rise, m_fall, m_flip;
    logic [2*D-1:0] m_hist, m_win;

    function automatic logic [1:0] all_differ(input logic [2*D-1:0] h, input logic [1:0] o);
        logic [1:0] r;
        r = 2'b11;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < D; k++)
                if (h[2*k+b] == o[b]) r[b] = 1'b0;
        return r;
    endfunction

    assign m_win  = {m_hist[2*D-3:0], m_s};
    assign m_flip = all_differ(m_win, m_o);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_s1   <= '0;
            m_s    <= '0;
            m_o    <= '0;
            m_rise <= '0;
            m_fall <= '0;
            m_hist <= '0;
        end else begin
            m_hist <= m_win;
            m_o    <= m_o ^ m_flip;
            m_rise <= m_flip & ~m_o;
            m_fall <= m_flip & m_o;
            m_s    <= m_s1;
            m_s1   <= bus.I;
        end
    end

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got O/RISE/FALL=%b required=%b at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] i;
        logic [1:0] o;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [1:0] i, input logic [1:0] o, input logic [1:0] r,
                                input logic [1:0] f);
        vec_t v;
        v.i = i; v.o = o; v.rise = r; v.fall = f;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        // Release with pins high, then drop bit 1 once both are qualified.
        for (int n = 0; n < 5; n++) tbl[n] = mk(2'b11, 2'b00, 2'b00, 2'b00);
        tbl[5] = mk(2'b11, 2'b11, 2'b11, 2'b00);
        tbl[6] = mk(2'b11, 2'b11, 2'b00, 2'b00);
        for (int n = 7; n < 12; n++) tbl[n] = mk(2'b01, 2'b11, 2'b00, 2'b00);
        tbl[12] = mk(2'b01, 2'b01, 2'b00, 2'b10);
        tbl[13] = mk(2'b01, 2'b01, 2'b00, 2'b00);

        rstn   = 1'b0;
        bus.I  = 2'b11;
        bus1.I = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_hold", {bus.O, bus.RISE, bus.FALL}, 6'b0);
        check("reset_hold_d1", {bus1.O, bus1.RISE, bus1.FALL}, 6'b0);

        rstn = 1'b1;
        for (int n = 0; n < 14; n++) begin
            bus.I = tbl[n].i;
            @(negedge clk);
            check($sformatf("table_row%0d", n), {bus.O, bus.RISE, bus.FALL},
                  {tbl[n].o, tbl[n].rise, tbl[n].fall});
        end

        // Back to 00 for the short-pulse test.
        bus.I = 2'b00;
        repeat (8) @(negedge clk);
        check("back_to_00", {bus.O, bus.RISE, bus.FALL}, 6'b0);

        // 3-cycle pulse must be rejected.
        bus.I = 2'b01;
        for (int n = 0; n < 10; n++) begin
            if (n == 3) bus.I = 2'b00;
            @(negedge clk);
            check($sformatf("short_pulse%0d", n), {bus.O, bus.RISE, bus.FALL}, 6'b0);
        end

        // Toggle 1,0,1 then hold: qualification counts from the last toggle.
        bus.I = 2'b01;
        @(negedge clk);
        bus.I = 2'b00;
        @(negedge clk);
        bus.I = 2'b01;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check($sformatf("toggle_edge%0d", n), {bus.O, bus.RISE, bus.FALL},
                  {(n >= 6) ? 2'b01 : 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00});
        end

        // Reset mid-count discards the partial count.
        bus.I = 2'b00;
        repeat (8) @(negedge clk);
        check("before_midreset", {bus.O, bus.RISE, bus.FALL}, 6'b0);
        bus.I = 2'b01;
        repeat (5) @(negedge clk);
        check("midcount", {bus.O, bus.RISE, bus.FALL}, 6'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            check($sformatf("requalify_edge%0d", n), {bus.O, bus.RISE, bus.FALL},
                  {(n >= 6) ? 2'b01 : 2'b00, (n == 6) ? 2'b01 : 2'b00, 2'b00});
        end

        // D=1 build: one synced cycle high gives RISE then FALL.
        bus1.I = 2'b10;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            bus1.I = 2'b00;
            check($sformatf("d1_edge%0d", n), {bus1.O, bus1.RISE, bus1.FALL},
                  {(n == 3) ? 2'b10 : 2'b00, (n == 3) ? 2'b10 : 2'b00,
                   (n == 4) ? 2'b10 : 2'b00});
        end

        // Asynchronous clear of a qualified level, no clock edge needed.
        check("pre_async", {bus.O, bus.RISE, bus.FALL}, 6'b010000);
        #2;
        rstn = 1'b0;
        #1;
        check("async_clear", {bus.O, bus.RISE, bus.FALL}, 6'b0);
        @(negedge clk);
        rstn = 1'b1;

        // Random run with sticky inputs so both accepts and rejections happen.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            check("random", {bus.O, bus.RISE, bus.FALL}, {m_o, m_rise, m_fall});
            for (int b = 0; b < 2; b++)
                if ($urandom_range(5) == 0) bus.I[b] = ~bus.I[b];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
